if_prefetch: RTL and testbench

- Parametrised instruction-fetch unit; successor to the single-register PC stage of the core.
- Owns the fetch PC and drives the instruction Wishbone master port.
- Buffers up to DEPTH fetched words in a prefetch queue ahead of decode.
- Handles pipeline redirects (branch/trap) and bus errors, including discard of an in-flight response after a redirect.

---
 rtl/if_pkg.sv | 21 ++
 rtl/if_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 132 +++++++++++++
 tb/tb_if_prefetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDiscard,
    StHalt
  } state_e;

  localparam logic [3:0]  WB_SEL_WORD = 4'hF;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned XLEN        = 32;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched entries; flush empties it in one cycle.
module if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // Push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Pointers are log2(DEPTH) wide, so increments wrap modulo DEPTH by truncation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch unit: owns the fetch PC, drives the Wishbone master and
// queues fetched words ahead of decode.
module if_prefetch import if_pkg::*; #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter int unsigned        DEPTH      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              if_ready_i,
  output logic              if_valid_o,
  output logic [31:0]       if_instr_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic              if_err_o,
  input  logic [31:0]       iwbm_dat_i,
  input  logic              iwbm_ack_i,
  input  logic              iwbm_err_i,
  output logic [ADDR_W-1:0] iwbm_addr_o,
  output logic [31:0]       iwbm_dat_o,
  output logic [3:0]        iwbm_sel_o,
  output logic              iwbm_we_o,
  output logic              iwbm_cyc_o,
  output logic              iwbm_stb_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W + 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   fetch_pc_q, addr_q;
  logic                cyc_q;
  logic [ADDR_W-1:0]   redirect_pc, pc_inc;
  logic                term;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INSTR_W-1:0]  push_instr;
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic [CNT_W-1:0]    count;
  logic [CNT_W:0]      count_after;

  assign redirect_pc = redirect_pc_i & ~ADDR_W'(3);
  assign term        = iwbm_ack_i | iwbm_err_i;
  assign pc_inc      = fetch_pc_q + ADDR_W'(4);
  assign fifo_pop    = if_valid_o & if_ready_i;
  // A response racing a redirect or reset belongs to the old stream and is dropped.
  assign fifo_push   = (state_q == StFetch) & term & ~redirect_i & ~rst_i;
  assign push_instr  = iwbm_err_i ? '0 : iwbm_dat_i;
  assign push_entry  = {fetch_pc_q, push_instr, iwbm_err_i};
  assign count_after = (CNT_W+1)'(count) + (CNT_W+1)'(1) - (CNT_W+1)'(fifo_pop);

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      cyc_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc;
            addr_q     <= redirect_pc;
            cyc_q      <= 1'b1;
            state_q    <= StFetch;
          end else if (state_q == StIdle && !fifo_full) begin
            addr_q  <= fetch_pc_q;
            cyc_q   <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc;
            if (term) begin
              addr_q <= redirect_pc;
            end else begin
              state_q <= StDiscard;
            end
          end else if (iwbm_err_i) begin
            cyc_q   <= 1'b0;
            state_q <= StHalt;
          end else if (iwbm_ack_i) begin
            fetch_pc_q <= pc_inc;
            addr_q     <= pc_inc;
            if (count_after >= (CNT_W+1)'(DEPTH)) begin
              cyc_q   <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StDiscard: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc;
          end
          if (term) begin
            addr_q  <= redirect_i ? redirect_pc : fetch_pc_q;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_valid_o = ~fifo_empty;
  assign {if_pc_o, if_instr_o, if_err_o} = fifo_empty ? '0 : head_entry;

  assign iwbm_addr_o = addr_q;
  assign iwbm_cyc_o  = cyc_q;
  assign iwbm_stb_o  = cyc_q;
  assign iwbm_dat_o  = '0;
  assign iwbm_sel_o  = WB_SEL_WORD;
  assign iwbm_we_o   = 1'b0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the fetch stream.
module tb_if_prefetch;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, redirect = 1'b0, ready = 1'b1, ack = 1'b0, err = 1'b0;
  logic [31:0] rpc = '0, dat = '0;
  logic        if_valid, if_err, wb_we, cyc, stb;
  logic [31:0] if_instr, if_pc, wb_addr, wb_dat_o;
  logic [3:0]  wb_sel;

  if_prefetch #(
    .ADDR_W     (32),
    .RESET_ADDR (RST_PC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .if_ready_i    (ready),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_err_o      (if_err),
    .iwbm_dat_i    (dat),
    .iwbm_ack_i    (ack),
    .iwbm_err_i    (err),
    .iwbm_addr_o   (wb_addr),
    .iwbm_dat_o    (wb_dat_o),
    .iwbm_sel_o    (wb_sel),
    .iwbm_we_o     (wb_we),
    .iwbm_cyc_o    (cyc),
    .iwbm_stb_o    (stb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected delivery queue and expected next fetch address.
  entry_t      q[$];
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] txn_addr = '0;
  bit          halted = 0, in_flight = 0, tainted = 0;
  int          txn_count = 0, delivered = 0;
  logic [31:0] err_pc_obs = '1, err_instr_obs = '1;

  // Bus slave knobs.
  bit          s_active = 0, rand_lat = 0, rand_err = 0, err_en = 0;
  bit          force_ack = 0, redir_on_ack = 0;
  int          s_cnt = 0, s_lat = 0, lat_cfg = 0;
  logic [31:0] err_addr = '0, redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    chk("stb_eq_cyc", 64'(stb), 64'(cyc));
    chk("wb_dat_o", 64'(wb_dat_o), 64'h0);
    chk("wb_sel", 64'(wb_sel), 64'hF);
    chk("wb_we", 64'(wb_we), 64'h0);
    chk("if_valid", 64'(if_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_pc", 64'(if_pc), 64'(q[0].pc));
      chk("if_instr", 64'(if_instr), 64'(q[0].instr));
      chk("if_err", 64'(if_err), 64'(q[0].err));
    end else begin
      chk("empty_pc", 64'(if_pc), 64'h0);
      chk("empty_instr", 64'(if_instr), 64'h0);
      chk("empty_err", 64'(if_err), 64'h0);
    end
    if (if_valid === 1'b1 && if_err === 1'b1) begin
      err_pc_obs    = if_pc;
      err_instr_obs = if_instr;
    end
    if (in_flight) begin
      chk("cyc_held", 64'(cyc), 64'h1);
      chk("addr_stable", 64'(wb_addr), 64'(txn_addr));
    end else if (cyc === 1'b1) begin
      chk("fetch_addr", 64'(wb_addr), 64'(exp_fetch));
      chk("no_fetch_when_halted", 64'(halted), 64'h0);
      chk("room_at_issue", 64'(q.size() < DEPTH), 64'h1);
      in_flight = 1;
      tainted   = 0;
      txn_addr  = wb_addr;
      txn_count++;
    end
    if (rst) begin
      q.delete();
      exp_fetch = RST_PC;
      halted    = 0;
      in_flight = 0;
    end else begin
      if (redirect) begin
        q.delete();
        exp_fetch = rpc & 32'hFFFF_FFFC;
        halted    = 0;
        if (in_flight) tainted = 1;
      end else if (ready && q.size() != 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (in_flight && (ack || err)) begin
        in_flight = 0;
        if (!tainted) begin
          if (err) begin
            q.push_back('{pc: txn_addr, instr: 32'h0, err: 1'b1});
            halted = 1;
          end else begin
            q.push_back('{pc: txn_addr, instr: dat, err: 1'b0});
            exp_fetch = txn_addr + 32'd4;
          end
        end
      end
    end
  endtask

  // One clock: slave response, model check/update, then the edge.
  task automatic cycle();
    bit auto_redir = 0;
    ack = 1'b0;
    err = 1'b0;
    dat = 32'hDEAD_0000;
    if (cyc !== 1'b1) begin
      s_active = 0;
    end else begin
      if (!s_active) begin
        s_active = 1;
        s_cnt    = 0;
        s_lat    = rand_lat ? int'($urandom_range(3, 0)) : lat_cfg;
      end
      if (s_cnt == s_lat) begin
        s_active = 0;
        if ((err_en && wb_addr == err_addr) || (rand_err && $urandom_range(19, 0) == 0)) begin
          err = 1'b1;
        end else begin
          ack = 1'b1;
          dat = mem_word(wb_addr);
        end
        if (redir_on_ack) begin
          redirect     = 1'b1;
          rpc          = redir_target;
          redir_on_ack = 0;
          auto_redir   = 1;
        end
      end else begin
        s_cnt++;
      end
    end
    if (force_ack) begin
      ack       = 1'b1;
      dat       = 32'hBAD0_BAD0;
      force_ack = 0;
    end
    model_step();
    @(posedge clk);
    #1;
    if (auto_redir) redirect = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int base;
    @(posedge clk);
    #1;
    cycle();
    chk("rst_cyc", 64'(cyc), 64'h0);
    chk("rst_valid", 64'(if_valid), 64'h0);
    chk("rst_err", 64'(if_err), 64'h0);
    chk("rst_pc", 64'(if_pc), 64'h0);
    rst = 1'b0;

    // Straight-line fetch with single-cycle acks.
    cycle();
    chk("first_addr", 64'(wb_addr), 64'h100);
    cycle();
    chk("first_valid", 64'(if_valid), 64'h1);
    chk("first_pc", 64'(if_pc), 64'h100);
    chk("second_addr", 64'(wb_addr), 64'h104);
    run(10);

    // Backpressure: queue fills, bus idles, one pop frees one fetch.
    ready = 1'b0;
    redirect = 1'b1;
    rpc = 32'h100;
    cycle();
    redirect = 1'b0;
    base = txn_count;
    run(12);
    chk("bp_issued", 64'(txn_count - base), 64'd4);
    chk("bp_cyc_low", 64'(cyc), 64'h0);
    chk("bp_head", 64'(if_pc), 64'h100);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    run(8);
    chk("bp_one_more", 64'(txn_count - base), 64'd5);
    chk("bp_refetch_addr", 64'(txn_addr), 64'h110);
    chk("bp_head2", 64'(if_pc), 64'h104);

    // Redirect while a slow cycle is outstanding.
    ready = 1'b1;
    lat_cfg = 3;
    for (int i = 0; i < 30 && !(cyc && s_active && s_lat == 3 && s_cnt >= 1); i++) cycle();
    chk("wait_inflight", 64'(cyc && s_active), 64'h1);
    redirect = 1'b1;
    rpc = 32'h2003;
    cycle();
    redirect = 1'b0;
    chk("rdr_flush", 64'(if_valid), 64'h0);
    base = txn_count;
    for (int i = 0; i < 20 && txn_count == base; i++) cycle();
    chk("rdr_addr", 64'(txn_addr), 64'h2000);
    run(12);

    // Redirect in the same cycle as the ack.
    lat_cfg = 2;
    redir_target = 32'h3000;
    redir_on_ack = 1;
    for (int i = 0; i < 20 && redir_on_ack; i++) cycle();
    chk("coinc_flush", 64'(if_valid), 64'h0);
    chk("coinc_cyc", 64'(cyc), 64'h1);
    chk("coinc_addr", 64'(wb_addr), 64'h3000);
    run(10);

    // Bus error halts fetch until a redirect.
    lat_cfg = 1;
    err_en = 1;
    err_addr = 32'h104;
    redirect = 1'b1;
    rpc = 32'h100;
    cycle();
    redirect = 1'b0;
    run(30);
    chk("err_pc", 64'(err_pc_obs), 64'h104);
    chk("err_instr", 64'(err_instr_obs), 64'h0);
    chk("halt_no_cyc", 64'(cyc), 64'h0);
    err_en = 0;
    redirect = 1'b1;
    rpc = 32'h200;
    cycle();
    redirect = 1'b0;
    base = txn_count;
    for (int i = 0; i < 10 && txn_count == base; i++) cycle();
    chk("post_halt_addr", 64'(txn_addr), 64'h200);
    run(6);

    // Fetch PC wraps past the top of the address space.
    lat_cfg = 0;
    redirect = 1'b1;
    rpc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    base = txn_count;
    for (int i = 0; i < 10 && txn_count < base + 2; i++) cycle();
    chk("wrap_addr", 64'(txn_addr), 64'h0);
    run(4);

    // Reset with a cycle outstanding; a stray ack afterwards is ignored.
    lat_cfg = 3;
    for (int i = 0; i < 30 && !(cyc && s_active && s_cnt >= 1); i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_cyc", 64'(cyc), 64'h0);
    force_ack = 1;
    cycle();
    chk("rst_ign_valid", 64'(if_valid), 64'h0);
    base = txn_count;
    for (int i = 0; i < 10 && txn_count == base; i++) cycle();
    chk("rst_restart_addr", 64'(txn_addr), 64'(RST_PC));
    run(20);

    // Randomized traffic.
    rand_lat = 1;
    rand_err = 1;
    base = delivered;
    for (int i = 0; i < 3000; i++) begin
      ready    = ($urandom_range(9, 0) < 7);
      redirect = halted ? ($urandom_range(3, 0) == 0) : ($urandom_range(39, 0) == 0);
      rpc      = $urandom();
      rst      = ($urandom_range(299, 0) == 0);
      cycle();
    end
    rst = 1'b0;
    redirect = 1'b0;
    chk("random_liveness", 64'(delivered - base > 300), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
